// File: rtl/demux1to2_stream.sv
// Handshaked 1-to-2 stream demultiplexer with one registered slot per output.
// Routing comes from in_sel, or from an alternating pointer when alt_mode=1.
module demux1to2_stream #(
  parameter int num_bits = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [num_bits-1:0] in_data,
  input  logic                in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                alt_mode,
  output logic [num_bits-1:0] out0_data,
  output logic [num_bits-1:0] out1_data,
  output logic                out0_valid,
  output logic                out1_valid,
  input  logic                out0_ready,
  input  logic                out1_ready,
  output logic                ptr
);

  logic [num_bits-1:0] r_data0_p1;
  logic [num_bits-1:0] r_data1_p1;
  logic                r_vld0_p1;
  logic                r_vld1_p1;
  logic                r_ptr;

  logic w_tgt;
  logic w_free0;
  logic w_free1;
  logic w_acc;
  logic w_load0;
  logic w_load1;

  // A slot is free when empty or being drained this very cycle.
  assign w_tgt    = alt_mode ? r_ptr : in_sel;
  assign w_free0  = ~r_vld0_p1 | out0_ready;
  assign w_free1  = ~r_vld1_p1 | out1_ready;
  assign in_ready = w_tgt ? w_free1 : w_free0;
  assign w_acc    = in_valid & in_ready;
  assign w_load0  = w_acc & ~w_tgt;
  assign w_load1  = w_acc & w_tgt;

  // p0 -> p1: input beat captured into the target output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data0_p1 <= '0;
      r_data1_p1 <= '0;
      r_vld0_p1  <= 1'b0;
      r_vld1_p1  <= 1'b0;
      r_ptr      <= 1'b0;
    end else begin
      if (w_load0) begin
        r_data0_p1 <= in_data;
        r_vld0_p1  <= 1'b1;
      end else if (r_vld0_p1 && out0_ready) begin
        r_vld0_p1  <= 1'b0;
      end

      if (w_load1) begin
        r_data1_p1 <= in_data;
        r_vld1_p1  <= 1'b1;
      end else if (r_vld1_p1 && out1_ready) begin
        r_vld1_p1  <= 1'b0;
      end

      if (w_acc && alt_mode) begin
        r_ptr <= ~r_ptr;
      end
    end
  end

  assign out0_data  = r_data0_p1;
  assign out1_data  = r_data1_p1;
  assign out0_valid = r_vld0_p1;
  assign out1_valid = r_vld1_p1;
  assign ptr        = r_ptr;

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed self-checking bench for demux1to2_stream: routing, alternation,
// backpressure, cross-output independence and asynchronous reset.
module tb_demux1to2_stream;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic       alt_mode;
  logic [7:0] out0_data;
  logic [7:0] out1_data;
  logic       out0_valid;
  logic       out1_valid;
  logic       out0_ready;
  logic       out1_ready;
  logic       ptr;

  int n_checks = 0;
  int n_errors = 0;

  demux1to2_stream #(.num_bits(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alt_mode   (alt_mode),
    .out0_data  (out0_data),
    .out1_data  (out1_data),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .out0_ready (out0_ready),
    .out1_ready (out1_ready),
    .ptr        (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_data = 8'h77; in_sel = 1'b0; in_valid = 1'b1;
    alt_mode = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;

    // Reset state, with a beat presented that must be discarded
    repeat (2) @(posedge clk);
    #2;
    chk("rst_v0", out0_valid, 0);
    chk("rst_v1", out1_valid, 0);
    chk("rst_d0", out0_data, 0);
    chk("rst_d1", out1_data, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_rdy", in_ready, 1);

    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_v0", out0_valid, 0);

    // Explicit routing
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h00;
    #1 chk("exp_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_sel = 1'b1; in_data = 8'hFF;
    #1;
    chk("exp_v0_a", out0_valid, 1);
    chk("exp_d0", out0_data, 8'h00);
    chk("exp_v1_a", out1_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("exp_v0_b", out0_valid, 0);
    chk("exp_v1_b", out1_valid, 1);
    chk("exp_d1", out1_data, 8'hFF);
    @(posedge clk); #2;
    chk("exp_v1_c", out1_valid, 0);
    chk("exp_ptr", ptr, 0);

    // Alternation 01..04 back-to-back
    alt_mode = 1'b1; in_valid = 1'b1; in_data = 8'h01;
    #1 chk("alt_rdy1", in_ready, 1);
    @(posedge clk); #1;
    in_data = 8'h02;
    #1;
    chk("alt_d0_01", out0_data, 8'h01);
    chk("alt_v0_01", out0_valid, 1);
    chk("alt_ptr1", ptr, 1);
    chk("alt_rdy2", in_ready, 1);
    @(posedge clk); #1;
    in_data = 8'h03;
    #1;
    chk("alt_d1_02", out1_data, 8'h02);
    chk("alt_v1_02", out1_valid, 1);
    chk("alt_v0_drn", out0_valid, 0);
    chk("alt_rdy3", in_ready, 1);
    @(posedge clk); #1;
    in_data = 8'h04;
    #1;
    chk("alt_d0_03", out0_data, 8'h03);
    chk("alt_v0_03", out0_valid, 1);
    chk("alt_rdy4", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("alt_d1_04", out1_data, 8'h04);
    chk("alt_v1_04", out1_valid, 1);
    chk("alt_ptr_end", ptr, 0);
    @(posedge clk); #2;
    chk("alt_v0_idle", out0_valid, 0);
    chk("alt_v1_idle", out1_valid, 0);

    // Backpressure on out0
    alt_mode = 1'b0; out0_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA5;
    #1 chk("bp_rdy1", in_ready, 1);
    @(posedge clk); #1;
    in_data = 8'h5A;
    #1;
    chk("bp_d0_a5", out0_data, 8'hA5);
    chk("bp_rdy_blk", in_ready, 0);
    @(posedge clk); #2;
    chk("bp_d0_hold", out0_data, 8'hA5);
    chk("bp_v0_hold", out0_valid, 1);
    chk("bp_rdy_blk2", in_ready, 0);
    out0_ready = 1'b1;
    #1 chk("bp_rdy_open", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out0_ready = 1'b0;
    #1;
    chk("bp_d0_5a", out0_data, 8'h5A);
    chk("bp_v0_5a", out0_valid, 1);

    // Independence: out0 full and stalled, beat to out1 goes through
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h3C;
    #1 chk("ind_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("ind_d1", out1_data, 8'h3C);
    chk("ind_v1", out1_valid, 1);
    chk("ind_d0", out0_data, 8'h5A);
    chk("ind_v0", out0_valid, 1);

    // Drain both, then fill both with ptr left at 1
    out0_ready = 1'b1;
    @(posedge clk); #1;
    out0_ready = 1'b0; out1_ready = 1'b0;
    alt_mode = 1'b1; in_valid = 1'b1; in_data = 8'hC1;
    #1 chk("fill_rdy", in_ready, 1);
    @(posedge clk); #1;
    alt_mode = 1'b0; in_sel = 1'b1; in_data = 8'hC2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("fill_v0", out0_valid, 1);
    chk("fill_v1", out1_valid, 1);
    chk("fill_d0", out0_data, 8'hC1);
    chk("fill_d1", out1_data, 8'hC2);
    chk("fill_ptr", ptr, 1);

    // Asynchronous reset between edges
    rst = 1'b1;
    #1;
    chk("ar_v0", out0_valid, 0);
    chk("ar_v1", out1_valid, 0);
    chk("ar_d0", out0_data, 0);
    chk("ar_d1", out1_data, 0);
    chk("ar_ptr", ptr, 0);
    chk("ar_rdy", in_ready, 1);
    in_valid = 1'b1; in_data = 8'hEE; out0_ready = 1'b1; out1_ready = 1'b1;
    @(posedge clk); #2;
    chk("ar_disc_v1", out1_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0; alt_mode = 1'b1; in_data = 8'hD1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("ar_first_v0", out0_valid, 1);
    chk("ar_first_d0", out0_data, 8'hD1);
    chk("ar_first_v1", out1_valid, 0);
    chk("ar_first_ptr", ptr, 1);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
